i2s_timing_ctrl: RTL and testbench

I2S_TIMING_CTRL -- requirements
Module: i2s_timing_ctrl

---
 rtl/i2s_timing_ctrl_if.sv | 31 +++
 rtl/i2s_timing_ctrl.sv | 155 +++++++++++++++
 tb/tb_i2s_timing_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_timing_ctrl_if.sv
// Control/status bundle for the I2S timing generator.
// frame_count exists only when I2S_TIMING_CTRL_FRAME_CNT_EN is defined.
interface i2s_timing_ctrl_if;
   logic        start;
   logic        stop;
   logic        bclk;
   logic        lrclk;
   logic        enabled;
   logic        busy;
   logic        frame_strobe;
`ifdef I2S_TIMING_CTRL_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   // master: the timing generator itself; slave: the sequencer that requests streaming
   modport master (
      input  start, stop,
      output bclk, lrclk, enabled, busy, frame_strobe
`ifdef I2S_TIMING_CTRL_FRAME_CNT_EN
      , output frame_count
`endif
   );

   modport slave (
      output start, stop,
      input  bclk, lrclk, enabled, busy, frame_strobe
`ifdef I2S_TIMING_CTRL_FRAME_CNT_EN
      , input frame_count
`endif
   );
endinterface

// File: rtl/i2s_timing_ctrl.sv
// I2S bclk/lrclk generator with arm/run/drain sequencing of the serdes enable.
// Optional frame counter enabled by macro I2S_TIMING_CTRL_FRAME_CNT_EN.
//
// state | meaning
// IDLE  | clocks parked low, accumulator and counters cleared
// ARM   | clocks running, waiting ARM_FRAMES frame strobes before enabling serdes
// RUN   | clocks running, serdes enabled
// DRAIN | clocks running until the next frame strobe, then back to IDLE
module i2s_timing_ctrl #(
   parameter int ACC_WIDTH        = 24,
   parameter int BCLK_INC         = 2061584,
   parameter int HALF_FRAME_BCLKS = 32,
   parameter int ARM_FRAMES       = 1
) (
   input logic              clk,
   input logic              reset_n,
   i2s_timing_ctrl_if.master bus
);

   localparam int HC_W = (HALF_FRAME_BCLKS > 1) ? $clog2(HALF_FRAME_BCLKS) : 1;
   localparam int AC_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
   localparam logic [ACC_WIDTH:0] INC_EXT  = (ACC_WIDTH+1)'(BCLK_INC);
   localparam logic [HC_W-1:0]    HC_LAST  = HC_W'(HALF_FRAME_BCLKS - 1);
   localparam logic [AC_W-1:0]    ARM_LAST = AC_W'(ARM_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

   state_t               state;
   logic [ACC_WIDTH-1:0] acc, acc_nx;
   logic [HC_W-1:0]      half_cnt, half_nx;
   logic [AC_W-1:0]      arm_cnt;
   logic                 bclk_q, lrclk_q, enabled_q, strobe_q;
   logic                 bclk_nx, lrclk_nx;
   logic [ACC_WIDTH:0]   sum;
   logic                 tick, bclk_fall, strobe_evt;

   // Carry out of the accumulator is the bclk toggle request; the residue stays in acc.
   always_comb begin
      sum        = {1'b0, acc} + INC_EXT;
      tick       = sum[ACC_WIDTH];
      acc_nx     = sum[ACC_WIDTH-1:0];
      bclk_nx    = bclk_q ^ tick;
      bclk_fall  = tick && bclk_q;
      half_nx    = half_cnt;
      lrclk_nx   = lrclk_q;
      strobe_evt = 1'b0;
      if (bclk_fall) begin
         if (half_cnt == HC_LAST) begin
            half_nx    = '0;
            lrclk_nx   = ~lrclk_q;
            strobe_evt = lrclk_q;
         end else begin
            half_nx = half_cnt + HC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         acc       <= '0;
         half_cnt  <= '0;
         arm_cnt   <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b0;
         enabled_q <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  state   <= ARM;
                  arm_cnt <= '0;
               end
            end
            ARM: begin
               if (bus.stop) begin
                  state    <= IDLE;
                  acc      <= '0;
                  half_cnt <= '0;
                  arm_cnt  <= '0;
                  bclk_q   <= 1'b0;
                  lrclk_q  <= 1'b0;
                  strobe_q <= 1'b0;
               end else begin
                  acc      <= acc_nx;
                  half_cnt <= half_nx;
                  bclk_q   <= bclk_nx;
                  lrclk_q  <= lrclk_nx;
                  strobe_q <= strobe_evt;
                  if (strobe_evt) begin
                     if (arm_cnt == ARM_LAST) begin
                        state     <= RUN;
                        enabled_q <= 1'b1;
                     end else begin
                        arm_cnt <= arm_cnt + AC_W'(1);
                     end
                  end
               end
            end
            RUN: begin
               acc      <= acc_nx;
               half_cnt <= half_nx;
               bclk_q   <= bclk_nx;
               lrclk_q  <= lrclk_nx;
               strobe_q <= strobe_evt;
               if (bus.stop) state <= DRAIN;
            end
            DRAIN: begin
               // enabled drops with the closing strobe; park everything one cycle later
               if (strobe_q && !enabled_q) begin
                  state    <= IDLE;
                  acc      <= '0;
                  half_cnt <= '0;
                  arm_cnt  <= '0;
                  bclk_q   <= 1'b0;
                  lrclk_q  <= 1'b0;
                  strobe_q <= 1'b0;
               end else begin
                  acc      <= acc_nx;
                  half_cnt <= half_nx;
                  bclk_q   <= bclk_nx;
                  lrclk_q  <= lrclk_nx;
                  strobe_q <= strobe_evt;
                  if (strobe_evt) enabled_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef I2S_TIMING_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (state == IDLE && bus.start && !bus.stop) begin
         frame_cnt <= '0;
      end else if (strobe_q && enabled_q) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign bus.frame_count = frame_cnt;
`endif

   assign bus.bclk         = bclk_q;
   assign bus.lrclk        = lrclk_q;
   assign bus.enabled      = enabled_q;
   assign bus.busy         = (state != IDLE);
   assign bus.frame_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_timing_ctrl.sv
// Directed bench for i2s_timing_ctrl: ACC_WIDTH=4, BCLK_INC=4, HALF_FRAME_BCLKS=4, ARM_FRAMES=1.
// Frame-counter checks compile only with I2S_TIMING_CTRL_FRAME_CNT_EN.
module tb_i2s_timing_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   edge_n = 0;

   i2s_timing_ctrl_if bus();

   i2s_timing_ctrl #(
      .ACC_WIDTH(4), .BCLK_INC(4), .HALF_FRAME_BCLKS(4), .ARM_FRAMES(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // advance k rising edges, then settle 1 time unit past the last one
   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic step_to(input int n);
      step(n - edge_n);
   endtask

   // start is captured on the edge that becomes edge 0
   task automatic start_at0();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      edge_n = 0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
   endtask

   task automatic check_all_low(input string tag);
      check_val({tag, "_busy"},   bus.busy, 1'b0);
      check_val({tag, "_bclk"},   bus.bclk, 1'b0);
      check_val({tag, "_lrclk"},  bus.lrclk, 1'b0);
      check_val({tag, "_en"},     bus.enabled, 1'b0);
      check_val({tag, "_strobe"}, bus.frame_strobe, 1'b0);
   endtask

   initial begin
      int en_seen;
      int busy_seen;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_low("reset");
      reset_n = 1'b1;
      step(5);
      check_val("idle_hold_busy", bus.busy, 1'b0);

      // start, bclk/lrclk timing, arm to run
      start_at0();
      check_val("start_busy", bus.busy, 1'b1);
      check_val("start_bclk", bus.bclk, 1'b0);
      step_to(3);  check_val("bclk_e3", bus.bclk, 1'b0);
      step_to(4);  check_val("bclk_rise_e4", bus.bclk, 1'b1);
      step_to(8);  check_val("bclk_fall_e8", bus.bclk, 1'b0);
      step_to(12); check_val("bclk_rise_e12", bus.bclk, 1'b1);
      step_to(31); check_val("lrclk_e31", bus.lrclk, 1'b0);
      step_to(32); check_val("lrclk_rise_e32", bus.lrclk, 1'b1);
      step_to(63);
      check_val("lrclk_e63", bus.lrclk, 1'b1);
      check_val("arm_en_e63", bus.enabled, 1'b0);
      step_to(64);
      check_val("lrclk_fall_e64", bus.lrclk, 1'b0);
      check_val("strobe_e64", bus.frame_strobe, 1'b1);
      check_val("en_rise_e64", bus.enabled, 1'b1);
      step_to(65);
      check_val("strobe_e65", bus.frame_strobe, 1'b0);
      check_val("run_en_e65", bus.enabled, 1'b1);

      // stop mid-frame in RUN, drain to next strobe
      step_to(99);
      pulse_stop();
      check_val("drain_en_e100", bus.enabled, 1'b1);
      step_to(127);
      check_val("drain_en_e127", bus.enabled, 1'b1);
      check_val("drain_busy_e127", bus.busy, 1'b1);
      step_to(128);
      check_val("drain_strobe_e128", bus.frame_strobe, 1'b1);
      check_val("drain_en_e128", bus.enabled, 1'b0);
      step_to(129);
      check_all_low("drain_idle");
      step(20);
      check_val("drain_stay_busy", bus.busy, 1'b0);
      check_val("drain_stay_bclk", bus.bclk, 1'b0);

      // stop while ARM
      start_at0();
      step_to(5);
      check_val("arm_bclk_e5", bus.bclk, 1'b1);
      step_to(9);
      pulse_stop();
      check_all_low("arm_stop");
      en_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 80; i++) begin
         step(1);
         if (bus.enabled) en_seen++;
         if (bus.busy) busy_seen++;
      end
      check_val("arm_stop_en_seen", en_seen, 0);
      check_val("arm_stop_busy_seen", busy_seen, 0);

      // start+stop together in IDLE, start during RUN
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check_val("both_busy", bus.busy, 1'b0);
      step(20);
      check_val("both_busy_later", bus.busy, 1'b0);
      check_val("both_bclk_later", bus.bclk, 1'b0);
      start_at0();
      step_to(64);
      check_val("run2_en_e64", bus.enabled, 1'b1);
      step_to(69);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check_val("restart_busy", bus.busy, 1'b1);
      check_val("restart_en", bus.enabled, 1'b1);
      step_to(127);
      check_val("restart_lrclk_e127", bus.lrclk, 1'b1);
      check_val("restart_strobe_e127", bus.frame_strobe, 1'b0);
      step_to(128);
      check_val("restart_strobe_e128", bus.frame_strobe, 1'b1);
      check_val("restart_lrclk_e128", bus.lrclk, 1'b0);

      // asynchronous reset mid-RUN
      step_to(166);
      check_val("pre_rst_bclk", bus.bclk, 1'b1);
      check_val("pre_rst_lrclk", bus.lrclk, 1'b1);
      check_val("pre_rst_en", bus.enabled, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      check_all_low("async_rst");
      #2 reset_n = 1'b1;
      step(20);
      check_val("post_rst_busy", bus.busy, 1'b0);
      check_val("post_rst_bclk", bus.bclk, 1'b0);

`ifdef I2S_TIMING_CTRL_FRAME_CNT_EN
      begin
         int waited;
         start_at0();
         check_val("fc_clear_start", bus.frame_count, 32'd0);
         step_to(321);
         check_val("fc_five_frames", bus.frame_count, 32'd5);
         pulse_stop();
         waited = 0;
         while (bus.busy && waited < 200) begin
            step(1);
            waited++;
         end
         check_val("fc_drain_timeout", waited < 200, 1'b1);
         check_val("fc_after_drain", bus.frame_count, 32'd5);
         start_at0();
         check_val("fc_clear_restart", bus.frame_count, 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end
endmodule
